// File: rtl/sysid_regfile.sv
// System-identification register file for an Avalon-MM slave port.
// Serves build ID, build timestamp, a capability word and board info words.
// Also holds a scratch register, a 64-bit cycle counter with a coherent
// high-word shadow, and a seconds uptime counter driven by a prescaler.
module sysid_regfile #(
    parameter logic [31:0] ID_VALUE    = 32'h5054_0001,
    parameter logic [31:0] TIMESTAMP   = 32'h0,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned NUM_USER    = 4,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter logic [31:0] SCRATCH_RST = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     chipselect,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    input  logic [32*NUM_USER-1:0]   user_info,
    output logic [31:0]              readdata,
    output logic                     readdatavalid
);

    // Word addresses of the register map.
    localparam logic [31:0] A_ID      = 32'd0;
    localparam logic [31:0] A_TSTAMP  = 32'd1;
    localparam logic [31:0] A_CAPS    = 32'd2;
    localparam logic [31:0] A_SCRATCH = 32'd3;
    localparam logic [31:0] A_CYC_LO  = 32'd4;
    localparam logic [31:0] A_CYC_HI  = 32'd5;
    localparam logic [31:0] A_UPTIME  = 32'd6;
    localparam logic [31:0] A_CTRL    = 32'd7;
    localparam int unsigned A_USER0   = 8;

    localparam logic [31:0] CAPS_WORD = {8'(NUM_USER), 8'(ADDR_W), 16'h0002};

    // Prescaler sized to hold CLK_HZ-1; a 1 Hz clock degenerates to a 1-bit counter stuck at 0.
    localparam int unsigned        PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

    logic [31:0]        scratch_q, scratch_d;
    logic [63:0]        cyc_cnt_q, cyc_cnt_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        uptime_q, uptime_d;
    logic               freeze_q, freeze_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               rvalid_q, rvalid_d;

    logic [31:0] addr_ext;
    logic        wr_en;
    logic        rd_en;
    logic        clear;
    logic [31:0] rd_mux;

    assign addr_ext = 32'(address);
    assign wr_en    = chipselect & write;
    // A simultaneous write wins; no read is issued that cycle.
    assign rd_en    = chipselect & read & ~write;
    assign clear    = wr_en && (addr_ext == A_CTRL) && writedata[0];

    // Read multiplexer: current register contents selected by the word address.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rd_mux = 32'h0;
        case (addr_ext)
            A_ID:      rd_mux = ID_VALUE;
            A_TSTAMP:  rd_mux = TIMESTAMP;
            A_CAPS:    rd_mux = CAPS_WORD;
            A_SCRATCH: rd_mux = scratch_q;
            A_CYC_LO:  rd_mux = cyc_cnt_q[31:0];
            A_CYC_HI:  rd_mux = shadow_q;
            A_UPTIME:  rd_mux = uptime_q;
            A_CTRL:    rd_mux = {30'h0, freeze_q, 1'b0};
            default: begin
                for (int k = 0; k < int'(NUM_USER); k++) begin
                    if (addr_ext == 32'(A_USER0 + k)) begin
                        rd_mux = user_info[32*k +: 32];
                    end
                end
            end
        endcase
    end

    // Next-state logic for registers, counters and the read response.
    always_comb begin
        scratch_d  = scratch_q;
        freeze_d   = freeze_q;
        cyc_cnt_d  = cyc_cnt_q;
        presc_d    = presc_q;
        uptime_d   = uptime_q;
        shadow_d   = shadow_q;
        readdata_d = readdata_q;
        rvalid_d   = rd_en;

        if (wr_en && (addr_ext == A_SCRATCH)) begin
            scratch_d = writedata;
        end
        if (wr_en && (addr_ext == A_CTRL)) begin
            freeze_d = writedata[1];
        end

        // Counting is gated by the registered freeze bit.
        if (!freeze_q) begin
            cyc_cnt_d = cyc_cnt_q + 64'd1;
            if (presc_q == PRESC_MAX) begin
                presc_d  = '0;
                uptime_d = uptime_q + 32'd1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end

        // Reading the low word snapshots the high word so a LO/HI pair is coherent.
        if (rd_en && (addr_ext == A_CYC_LO)) begin
            shadow_d = cyc_cnt_q[63:32];
        end

        // Clear has priority over both increment and shadow capture.
        if (clear) begin
            cyc_cnt_d = '0;
            presc_d   = '0;
            uptime_d  = '0;
            shadow_d  = '0;
        end

        // readdata only changes when a read is issued, otherwise it holds.
        if (rd_en) begin
            readdata_d = rd_mux;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q  <= SCRATCH_RST;
            freeze_q   <= 1'b0;
            cyc_cnt_q  <= '0;
            presc_q    <= '0;
            uptime_q   <= '0;
            shadow_q   <= '0;
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
            scratch_q  <= scratch_d;
            freeze_q   <= freeze_d;
            cyc_cnt_q  <= cyc_cnt_d;
            presc_q    <= presc_d;
            uptime_q   <= uptime_d;
            shadow_q   <= shadow_d;
            readdata_q <= readdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_regfile.sv
// Self-checking bench for sysid_regfile: table-driven register accesses plus
// hand-written counter, control and reset sequences, checked by a scoreboard.
module tb_sysid_regfile;

    localparam logic [31:0] ID_VALUE    = 32'h5054_0001;
    localparam logic [31:0] TIMESTAMP   = 32'h6500_1234;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned NUM_USER    = 4;
    localparam int unsigned CLK_HZ      = 10;
    localparam logic [31:0] SCRATCH_RST = 32'hCAFE_0000;

    logic                   clk;
    logic                   reset_n;
    logic                   chipselect;
    logic [ADDR_W-1:0]      address;
    logic                   read;
    logic                   write;
    logic [31:0]            writedata;
    logic [32*NUM_USER-1:0] user_info;
    logic [31:0]            readdata;
    logic                   readdatavalid;

    sysid_regfile #(
        .ID_VALUE   (ID_VALUE),
        .TIMESTAMP  (TIMESTAMP),
        .ADDR_W     (ADDR_W),
        .NUM_USER   (NUM_USER),
        .CLK_HZ     (CLK_HZ),
        .SCRATCH_RST(SCRATCH_RST)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .chipselect   (chipselect),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .user_info    (user_info),
        .readdata     (readdata),
        .readdatavalid(readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  addr;
        bit          rd;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          due;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    function automatic logic [31:0] user_word(int k);
        return 32'h1111_0000 + 32'(k) * 32'h0101_0101;
    endfunction

    function automatic vec_t mk(string n, logic [3:0] a, bit rd, bit wr,
                                logic [31:0] wd, logic [31:0] ex);
        vec_t v;
        v.name = n; v.addr = a; v.rd = rd; v.wr = wr; v.wdata = wd; v.exp = ex;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at a falling edge, sampled at the next rising edge.
    task automatic bus(string name, logic [3:0] a, bit rd, bit wr,
                       logic [31:0] wd, logic [31:0] ex);
        chipselect = 1'b1;
        address    = a;
        read       = rd;
        write      = wr;
        writedata  = wd;
        if (rd && !wr) sb.push_back('{name: name, data: ex, due: cyc_n + 1});
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic idle(int n);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Response monitor: every valid must match the oldest expectation, exactly one cycle after issue.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc_n) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_valid"}, {31'h0, readdatavalid}, 32'h1);
            check(e.name, readdata, e.data);
        end else if (readdatavalid) begin
            check("unexpected_valid", {31'h0, readdatavalid}, 32'h0);
        end
    end

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        for (int k = 0; k < int'(NUM_USER); k++) user_info[32*k +: 32] = user_word(k);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_valid", {31'h0, readdatavalid}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Static map, RO write protection, user words and unmapped holes; back-to-back reads.
        vecs.push_back(mk("rd_id",       4'd0,  1, 0, 32'h0,         ID_VALUE));
        vecs.push_back(mk("rd_tstamp",   4'd1,  1, 0, 32'h0,         TIMESTAMP));
        vecs.push_back(mk("rd_caps",     4'd2,  1, 0, 32'h0,         32'h0404_0002));
        vecs.push_back(mk("rd_scr_rst",  4'd3,  1, 0, 32'h0,         SCRATCH_RST));
        vecs.push_back(mk("wr_scr",      4'd3,  0, 1, 32'hA5A5_5A5A, 32'h0));
        vecs.push_back(mk("rd_scr",      4'd3,  1, 0, 32'h0,         32'hA5A5_5A5A));
        vecs.push_back(mk("wr_id",       4'd0,  0, 1, 32'h0,         32'h0));
        vecs.push_back(mk("rd_id_ro",    4'd0,  1, 0, 32'h0,         ID_VALUE));
        vecs.push_back(mk("wr_tstamp",   4'd1,  0, 1, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk("rd_tstamp_ro",4'd1,  1, 0, 32'h0,         TIMESTAMP));
        vecs.push_back(mk("wr_caps",     4'd2,  0, 1, 32'h1234_5678, 32'h0));
        vecs.push_back(mk("rd_caps_ro",  4'd2,  1, 0, 32'h0,         32'h0404_0002));
        vecs.push_back(mk("rd_user0",    4'd8,  1, 0, 32'h0,         user_word(0)));
        vecs.push_back(mk("rd_user1",    4'd9,  1, 0, 32'h0,         user_word(1)));
        vecs.push_back(mk("rd_user2",    4'd10, 1, 0, 32'h0,         user_word(2)));
        vecs.push_back(mk("rd_user3",    4'd11, 1, 0, 32'h0,         user_word(3)));
        vecs.push_back(mk("rd_unmap12",  4'd12, 1, 0, 32'h0,         32'h0));
        vecs.push_back(mk("rd_unmap15",  4'd15, 1, 0, 32'h0,         32'h0));
        vecs.push_back(mk("wr_unmap12",  4'd12, 0, 1, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk("rd_unmap12b", 4'd12, 1, 0, 32'h0,         32'h0));
        vecs.push_back(mk("rd_scr_keep", 4'd3,  1, 0, 32'h0,         32'hA5A5_5A5A));
        vecs.push_back(mk("rd_ctrl_rst", 4'd7,  1, 0, 32'h0,         32'h0));
        foreach (vecs[i]) bus(vecs[i].name, vecs[i].addr, vecs[i].rd, vecs[i].wr,
                              vecs[i].wdata, vecs[i].exp);
        idle(2);

        // Coherent 64-bit read across a low-word wrap.
        force dut.cyc_cnt_q = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.cyc_cnt_q;
        bus("cyc_lo_wrap", 4'd4, 1, 0, 32'h0, 32'hFFFF_FFFF);
        bus("cyc_hi_shadow", 4'd5, 1, 0, 32'h0, 32'h0000_0001);

        // Freeze holds the count; CLEAR while frozen zeroes counters and shadow.
        bus("wr_freeze", 4'd7, 0, 1, 32'h2, 32'h0);
        bus("frz_lo_a", 4'd4, 1, 0, 32'h0, 32'h0000_0002);
        idle(20);
        bus("frz_lo_b", 4'd4, 1, 0, 32'h0, 32'h0000_0002);
        bus("frz_hi", 4'd5, 1, 0, 32'h0, 32'h0000_0002);
        bus("wr_frz_clr", 4'd7, 0, 1, 32'h3, 32'h0);
        bus("clr_hi", 4'd5, 1, 0, 32'h0, 32'h0);
        bus("clr_lo", 4'd4, 1, 0, 32'h0, 32'h0);
        bus("clr_sec", 4'd6, 1, 0, 32'h0, 32'h0);
        bus("ctrl_frozen", 4'd7, 1, 0, 32'h0, 32'h2);
        idle(5);
        bus("clr_lo_held", 4'd4, 1, 0, 32'h0, 32'h0);

        // Unfreeze: counting resumes from 0; prescaler of 10 gives 3 seconds after 35 cycles.
        bus("wr_unfreeze", 4'd7, 0, 1, 32'h0, 32'h0);
        idle(34);
        bus("sec_3", 4'd6, 1, 0, 32'h0, 32'd3);
        bus("run_lo", 4'd4, 1, 0, 32'h0, 32'd35);
        bus("run_hi", 4'd5, 1, 0, 32'h0, 32'd0);
        bus("pre_clr_lo", 4'd4, 1, 0, 32'h0, 32'd37);
        bus("wr_clear", 4'd7, 0, 1, 32'h1, 32'h0);
        bus("post_clr_lo", 4'd4, 1, 0, 32'h0, 32'd0);
        bus("ctrl_selfclr", 4'd7, 1, 0, 32'h0, 32'h0);
        bus("post_clr_sec", 4'd6, 1, 0, 32'h0, 32'd0);
        idle(2);

        // Read and write together: the write happens and no response is produced.
        bus("rdwr_same", 4'd3, 1, 1, 32'h1234_5678, 32'h0);
        check("rdwr_no_valid", {31'h0, readdatavalid}, 32'h0);
        bus("rdwr_scr", 4'd3, 1, 0, 32'h0, 32'h1234_5678);
        idle(3);
        check("hold_readdata", readdata, 32'h1234_5678);
        check("hold_valid", {31'h0, readdatavalid}, 32'h0);

        // Reset asserted while a read is presented: no response ever appears.
        chipselect = 1'b1;
        address    = 4'd0;
        read       = 1'b1;
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        check("rstrd_valid", {31'h0, readdatavalid}, 32'h0);
        check("rstrd_readdata", readdata, 32'h0);
        chipselect = 1'b0;
        read       = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        check("rstrd_after_valid", {31'h0, readdatavalid}, 32'h0);
        bus("rd_scr_rst2", 4'd3, 1, 0, 32'h0, SCRATCH_RST);
        idle(3);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
